// File: rtl/quad_gate_tester_pkg.sv
// Shared types, function codes and the vector-rotation helper for the
// quad 2-input gate self-test sequencer.
package quad_gate_pkg;

   // Sequencer states.
   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      CHECK,
      DONE
   } state_e;

   // Expected gate function codes.
   localparam int FUNC_OR   = 0;
   localparam int FUNC_AND  = 1;
   localparam int FUNC_NAND = 2;
   localparam int FUNC_NOR  = 3;
   localparam int FUNC_XOR  = 4;

   localparam int NUM_GATES = 4;

   // Returns {a[3:0], b[3:0]} for vector index vec. Gate k gets
   // v_k = (vec + k) mod 4 with A = v_k[1] and B = v_k[0], so the four
   // gates always see four different input pairs.
   function automatic logic [7:0] rotate_vec(input logic [1:0] vec);
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] v;
      for (int k = 0; k < NUM_GATES; k++) begin
         v    = vec + 2'(k);
         a[k] = v[1];
         b[k] = v[0];
      end
      return {a, b};
   endfunction

endpackage

// File: rtl/quad_gate_tester_if.sv
// Signal bundle between the self-test sequencer, the board-level test
// controller and the gate part under test.
interface quad_gate_tester_if;

   logic       i_start;
   logic [3:0] i_y;
   logic [3:0] o_a;
   logic [3:0] o_b;
   logic       o_busy;
   logic       o_done;
   logic       o_pass;
   logic [3:0] o_fail_mask;
   logic [1:0] o_vec_idx;

   // Sequencer side.
   modport master (
      input  i_start,
      input  i_y,
      output o_a,
      output o_b,
      output o_busy,
      output o_done,
      output o_pass,
      output o_fail_mask,
      output o_vec_idx
   );

   // Controller / part side.
   modport slave (
      output i_start,
      output i_y,
      input  o_a,
      input  o_b,
      input  o_busy,
      input  o_done,
      input  o_pass,
      input  o_fail_mask,
      input  o_vec_idx
   );

endinterface

// File: rtl/quad_gate_ref.sv
// Combinational expected-Y model for four identical 2-input gates.
// FUNC selects the gate type; an unsupported code stops elaboration.
module quad_gate_ref
   import quad_gate_pkg::*;
#(
   parameter int FUNC = FUNC_OR
) (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [3:0] y_o
);

   generate
      if (FUNC < FUNC_OR || FUNC > FUNC_XOR) begin : g_bad_func
         $error("quad_gate_ref: unsupported FUNC code %0d", FUNC);
      end
   endgenerate

   // Expected outputs of all four gates for the configured function.
   always_comb begin
      case (FUNC)
         FUNC_AND:  y_o = a_i & b_i;
         FUNC_NAND: y_o = ~(a_i & b_i);
         FUNC_NOR:  y_o = ~(a_i | b_i);
         FUNC_XOR:  y_o = a_i ^ b_i;
         default:   y_o = a_i | b_i;
      endcase
   end

endmodule

// File: rtl/quad_gate_tester.sv
// Self-test sequencer for a quad 2-input gate part. On start it walks four
// rotating vectors, waits SETTLE_CYCLES after applying each, samples the
// part's Y outputs at the end of CHECK and accumulates a per-gate fail mask.
// Optional build macro QUAD_GATE_TESTER_STOP_ON_FAIL_EN ends the test at
// the first CHECK that sees any mismatch.
module quad_gate_tester
   import quad_gate_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int FUNC          = FUNC_OR
) (
   input  logic               i_clk,
   input  logic               i_reset,
   quad_gate_tester_if.master bus
);

   // A zero settle time still needs a legal one-bit counter.
   localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

   state_e           state_q;
   logic [1:0]       vec_q;
   logic [3:0]       a_q;
   logic [3:0]       b_q;
   logic [3:0]       mask_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [CNT_W-1:0] cnt_q;

   logic [3:0]       exp_y;
   logic [3:0]       mismatch_d;
   logic [3:0]       mask_d;
   logic             last_check_d;

   quad_gate_ref #(
      .FUNC (FUNC)
   ) u_ref (
      .a_i (a_q),
      .b_i (b_q),
      .y_o (exp_y)
   );

   // Mismatches in the current CHECK cycle and whether it ends the test.
   always_comb begin
      mismatch_d = bus.i_y ^ exp_y;
      mask_d     = mask_q | mismatch_d;
`ifdef QUAD_GATE_TESTER_STOP_ON_FAIL_EN
      last_check_d = (vec_q == 2'd3) || (mismatch_d != 4'b0000);
`else
      last_check_d = (vec_q == 2'd3);
`endif
   end

   // Sequencer FSM with all outputs registered.
   // NOTE: every register here uses non-blocking assignment so all of them
   // update together from the same pre-edge values; blocking assignment
   // would let later statements see half-updated state.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         vec_q   <= 2'd0;
         a_q     <= 4'b0000;
         b_q     <= 4'b0000;
         mask_q  <= 4'b0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         // NOTE: the default here makes o_done a single-cycle pulse without
         // having to clear it explicitly in every state.
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.i_start) begin
                  state_q    <= APPLY;
                  vec_q      <= 2'd0;
                  {a_q, b_q} <= rotate_vec(2'd0);
                  mask_q     <= 4'b0000;
                  pass_q     <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            APPLY: begin
               if (SETTLE_CYCLES > 0) begin
                  state_q <= SETTLE;
                  cnt_q   <= CNT_W'(SETTLE_CYCLES);
               end else begin
                  state_q <= CHECK;
               end
            end
            SETTLE: begin
               // Count down to zero and stay there; the last settle cycle
               // is the one that sees a count of one.
               if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q <= CNT_W'(1)) state_q <= CHECK;
            end
            CHECK: begin
               mask_q <= mask_d;
               if (last_check_d) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  pass_q  <= (mask_d == 4'b0000);
                  a_q     <= 4'b0000;
                  b_q     <= 4'b0000;
               end else begin
                  state_q    <= APPLY;
                  vec_q      <= vec_q + 2'd1;
                  {a_q, b_q} <= rotate_vec(vec_q + 2'd1);
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_a         = a_q;
   assign bus.o_b         = b_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_done      = done_q;
   assign bus.o_pass      = pass_q;
   assign bus.o_fail_mask = mask_q;
   assign bus.o_vec_idx   = vec_q;

endmodule

// File: doc/quad_gate_tester.md
# quad_gate_tester

Self-test sequencer for a quad 2-input logic gate part such as the SN54LS32 quad OR.
- On a start request it drives all four gates' A/B inputs through a rotating exhaustive vector set.
- It waits a programmable settle time for each vector, then samples the four Y outputs and compares them against the expected gate function.
- It reports a per-gate fail mask and an overall pass flag.
- It sits between a board-level test controller and the gate part under test.

## Interface

Parameters:
- SETTLE_CYCLES, 4, cycles to wait between applying a vector and sampling Y; 0 is legal.
- FUNC, 0, expected gate function: 0 OR, 1 AND, 2 NAND, 3 NOR, 4 XOR. Any other value is an elaboration error.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  start request; sampled only in IDLE.
- i_y  input  4  gate outputs from the part; bit k = gate k+1. Synchronous to i_clk; any synchronisation is done outside this block.
- o_a  output  4  A inputs to the part; bit k = gate k+1; registered.
- o_b  output  4  B inputs to the part; registered.
- o_busy  output  1  high from the first APPLY cycle through the last CHECK cycle.
- o_done  output  1  one-cycle pulse when the test completes.
- o_pass  output  1  high when the last completed test had an all-zero fail mask; held until the next start.
- o_fail_mask  output  4  sticky per-gate mismatch flags for the current or last test.
- o_vec_idx  output  2  current vector index, for debug.

## Operation

- States:
  - IDLE → APPLY on i_start.
  - APPLY → SETTLE when SETTLE_CYCLES > 0, otherwise APPLY → CHECK.
  - SETTLE → CHECK after SETTLE_CYCLES cycles.
  - CHECK → APPLY with vec+1 when vec < 3.
  - CHECK → DONE when vec == 3.
  - DONE → IDLE unconditionally.
- Vector rotation: gate k receives v_k = (vec + k) mod 4, with A = v_k[1] and B = v_k[0]. Every gate sees all four input pairs, and at any vector the four gates are all driven differently.
- Start: clears o_fail_mask, o_pass, and vec to 0.
- CHECK: compares i_y[k] against FUNC(o_a[k], o_b[k]) and ORs any mismatch into o_fail_mask[k].
- DONE:
  - o_done = 1 for one cycle.
  - o_pass = (o_fail_mask == 0), registered with the mask update from the final CHECK.
  - o_a and o_b return to 0.
- i_start while not IDLE is ignored. No queuing.
- The settle counter is $clog2(SETTLE_CYCLES+1) bits wide and saturates at zero. There is no wrap.

## Timing

- Reset values: state IDLE, o_a = 0, o_b = 0, o_busy = 0, o_done = 0, o_pass = 0, o_fail_mask = 0, o_vec_idx = 0.
- Reset asserted mid-test aborts immediately to the reset values. There is no o_done.
- The edge that samples i_start in IDLE enters APPLY. o_a and o_b hold vector 0 from that edge.
- Each vector occupies exactly SETTLE_CYCLES+2 cycles: 1 APPLY, SETTLE_CYCLES SETTLE, 1 CHECK. o_a and o_b are stable across all of them.
- i_y is sampled at the clock edge that ends CHECK.
- o_done rises 4·(SETTLE_CYCLES+2) cycles after the start-sampling edge. With default parameters that is 24 cycles.
- o_busy falls on the same edge on which o_done rises.
- Back-to-back tests: i_start held high through DONE is sampled in the following IDLE cycle. The minimum restart gap is 1 IDLE cycle.

## Configuration

- Macro QUAD_GATE_TESTER_STOP_ON_FAIL_EN.
- When defined: the first CHECK with any mismatch goes directly to DONE. o_vec_idx freezes at the failing vector and o_pass = 0.
- When undefined: all four vectors always run and the mask accumulates. Timing is fixed as above.

## Structure

- Package quad_gate_pkg holds:
  - the state enum (IDLE, APPLY, SETTLE, CHECK, DONE);
  - FUNC code localparams (FUNC_OR, FUNC_AND, FUNC_NAND, FUNC_NOR, FUNC_XOR);
  - the vector-rotation function returning {a, b} for a given vec.
- One sub-module, quad_gate_ref: combinational expected-Y model taking FUNC, a[3:0] and b[3:0]. It is reused by the bench as the golden model.

## Test plan

- Good OR part, default parameters: pulse i_start → at vec 0, o_a = 4'b1100, o_b = 4'b1010, expected i_y = 4'b1110. o_done pulses 24 cycles after start; o_pass = 1; o_fail_mask = 0.
- Gate 3 stuck-at-0 (i_y[2] forced 0) → o_fail_mask = 4'b0100, o_pass = 0, o_done still at cycle 24.
- SETTLE_CYCLES = 0, FUNC = 4 (XOR), good part → o_done at cycle 8; o_pass = 1.
- Reset asserted at cycle 10 of a test → all outputs are 0 on the next cycle and no o_done pulse. A new i_start runs a full test with a fresh mask.
- i_start pulsed at cycles 3 and 15 during a test → ignored: exactly one o_done, at cycle 24.
- With QUAD_GATE_TESTER_STOP_ON_FAIL_EN, gate 1 output inverted → o_done at cycle 6, o_vec_idx = 0, o_fail_mask = 4'b0001.
